axi_ahb_burst_sequencer: RTL
============================

// Module: axi_ahb_burst_sequencer
// PURPOSE
//  Address-phase engine of the AXI->AHB bridge. Accepts one AXI AW/AR command (len/size/burst/addr),
//  splits it into legal AHB bursts (no 1KB crossing, AHB has no WRAP2), and drives HTRANS/HADDR/HBURST/
//  HSIZE/HWRITE beat by beat under HREADY. Supports BUSY insertion from the data path.
//  Data phase (HWDATA/HRDATA/response) is handled by the bridge datapath.
// PARAMETERS
//  ADDR_W   32  address width
//  LEN_W    8   AXI len width (beats = len+1, up to 256)
//  DATA_W   32  AHB data width; SIZE_MAX = $clog2(DATA_W/8)
// PORTS
//  clk        in   1       clock
//  rst_n      in   1       async active-low reset
//  cmd_valid  in   1       command valid
//  cmd_ready  out  1       command accepted when valid&ready
//  cmd_write  in   1       1=write (AW), 0=read (AR)
//  cmd_addr   in   ADDR_W  AXI start address
//  cmd_len    in   LEN_W   AXI len
//  cmd_size   in   3       AXI size
//  cmd_burst  in   2       00 FIXED, 01 INCR, 10 WRAP, 11 reserved (treated as INCR)
//  hold       in   1       data path not ready; request BUSY/IDLE instead of next beat
//  hready     in   1       AHB HREADY
//  htrans     out  2       IDLE 00, BUSY 01, NONSEQ 10, SEQ 11
//  haddr      out  ADDR_W  AHB address
//  hburst     out  3       SINGLE 000, INCR 001, WRAP4 010, INCR4 011, WRAP8 100, INCR8 101, WRAP16 110, INCR16 111
//  hsize      out  3       = latched cmd_size
//  hwrite     out  1       = latched cmd_write
//  beat_done  out  1       htrans in {NONSEQ,SEQ} && hready (combinational)
//  beat_last  out  1       beat_done on final beat of the AXI command
//  cmd_err    out  1       1-cycle pulse: cmd_size > SIZE_MAX; command dropped, no AHB beats
// BEHAVIOUR
//  Reset (async): state IDLE; htrans=00, haddr=0, hburst=0, hsize=0, hwrite=0, cmd_err=0. cmd_ready=(state==IDLE) -> 1.
//  FSM: IDLE -> FIRST (NONSEQ) -> NEXT (SEQ) / HOLD (BUSY) -> FIRST (next chunk) or IDLE.
//  Accept cycle N -> NONSEQ on htrans at N+1 (all AHB outputs registered).
//  Advance only when hready=1; while hready=0 every AHB output is held stable.
//  Chunk planning at each chunk start: R = beats remaining, B = beats to next 1KB boundary
//  ((1024 - addr[9:0]) >> size). INCR: R>=16&&B>=16 -> INCR16; else R>=8&&B>=8 -> INCR8;
//  else R>=4&&B>=4 -> INCR4; else R==1 -> SINGLE; else INCR, chunk length min(R,B).
//  WRAP: beats 4/8/16 with container (beats<<size) <= 1KB -> WRAP4/8/16. Beats 2, other counts, or
//  container > 1KB -> every beat SINGLE NONSEQ, same wrapped address sequence.
//  FIXED: every beat SINGLE NONSEQ, same address.
//  Address: INCR next = addr + (1<<size); WRAP next = (addr & ~M) | ((addr + (1<<size)) & M),
//  M = (beats<<size)-1; computed at ADDR_W, wrap-around at 2^ADDR_W ignored (illegal AXI).
//  Every chunk's first beat is NONSEQ; later beats SEQ.
//  hold=1 when next beat would be SEQ -> htrans=BUSY, haddr=next beat address, until hold=0.
//  hold=1 at chunk start -> htrans=IDLE.
//  After last beat accepted: htrans=IDLE, state IDLE. New command may be accepted in that cycle
//  (NONSEQ the following cycle).
//  cmd_err: accepted command with illegal size -> pulse next cycle, stay IDLE.
//  Reset mid-burst: outputs to reset values immediately; remaining beats discarded.
// STRUCTURE
//  Package axi_ahb_pkg: htrans_t, hburst_t, axi_burst_t enums; KB_BOUNDARY=1024 constant.
//  Sub-module axi_ahb_burst_planner (combinational): (addr, remaining, size, burst, wrap beats)
//  -> hburst, chunk length. Top holds FSM, beat/chunk counters, address generator.
// TESTING
//  1 INCR len=15 addr=0x100 size=2 -> one INCR16: NONSEQ+15 SEQ, haddr 0x100..0x13C, beat_last on beat 16.
//  2 INCR len=15 addr=0x3F0 size=2 -> INCR4 0x3F0..0x3FC, NONSEQ INCR8 0x400..0x41C, NONSEQ INCR4 0x420..0x42C.
//  3 WRAP len=3 addr=0x38 size=2 -> WRAP4 haddr 0x38,0x3C,0x30,0x34; WRAP len=1 addr=0x4 -> SINGLE 0x4, SINGLE 0x0.
//  4 INCR len=2 addr=0 -> hburst=INCR, 3 beats 0x0,0x4,0x8; FIXED len=3 addr=0x10 -> 4x SINGLE NONSEQ @0x10.
//  5 INCR16: hready=0 2 cycles at beat 2, hold=1 2 cycles before beat 5 -> outputs stable, BUSY x2 with haddr of beat 5, no beat_done while stalled.
//  6 rst_n low mid-INCR8 beat 3 -> htrans=IDLE same cycle; after release cmd_ready=1; size=3 with DATA_W=32 -> cmd_err pulse, no beats.

Source files
------------

// File: rtl/axi_ahb_pkg.sv
// axi_ahb_pkg: shared AHB/AXI encodings and sequencer states for the AXI->AHB bridge
package axi_ahb_pkg;
    typedef enum logic [1:0] {HT_IDLE = 2'b00, HT_BUSY = 2'b01, HT_NONSEQ = 2'b10, HT_SEQ = 2'b11} htrans_t;
    typedef enum logic [2:0] {
        HB_SINGLE = 3'b000, HB_INCR = 3'b001, HB_WRAP4 = 3'b010, HB_INCR4 = 3'b011,
        HB_WRAP8 = 3'b100, HB_INCR8 = 3'b101, HB_WRAP16 = 3'b110, HB_INCR16 = 3'b111
    } hburst_t;
    typedef enum logic [1:0] {AB_FIXED = 2'b00, AB_INCR = 2'b01, AB_WRAP = 2'b10, AB_RSVD = 2'b11} axi_burst_t;
    typedef enum logic [2:0] {S_IDLE, S_FIRST, S_NEXT, S_BUSY, S_GAP} seq_state_t;
    localparam int KB_BOUNDARY = 1024;
    function automatic htrans_t trans_of(input seq_state_t s);
        return s == S_FIRST ? HT_NONSEQ : s == S_NEXT ? HT_SEQ : s == S_BUSY ? HT_BUSY : HT_IDLE;
    endfunction
endpackage

// File: rtl/axi_ahb_burst_planner.sv
// axi_ahb_burst_planner: picks AHB burst type and chunk length for the next chunk of an AXI command
module axi_ahb_burst_planner
    import axi_ahb_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic [9:0]     addr_lo,
    input  logic [LEN_W:0] remaining,
    input  logic [2:0]     size,
    input  logic [1:0]     burst,
    input  logic [LEN_W:0] wrap_beats,
    output logic [2:0]     hburst,
    output logic [LEN_W:0] chunk_len
);
    localparam int CW = (LEN_W + 1 > 11) ? LEN_W + 1 : 11;
    localparam int XW = CW + 8;
    localparam int RW = LEN_W + 1;
    logic [10:0]   kb_beats;
    logic [CW-1:0] kb_x, rem_x, run, wb, incr_len;
    logic [XW-1:0] container;
    logic          wrap_ok, is_wrap, is_single;
    always_comb begin
        kb_beats  = (11'(KB_BOUNDARY) - {1'b0, addr_lo}) >> size;
        // an unaligned start just below the boundary still owes one beat
        kb_x      = kb_beats == 11'd0 ? CW'(1) : CW'(kb_beats);
        rem_x     = CW'(remaining);
        run       = kb_x < rem_x ? kb_x : rem_x;
        wb        = CW'(wrap_beats);
        container = XW'(wb) << size;
        wrap_ok   = (wb == CW'(4) || wb == CW'(8) || wb == CW'(16)) && container <= XW'(KB_BOUNDARY);
        is_wrap   = burst == AB_WRAP;
        is_single = burst == AB_FIXED || (is_wrap && !wrap_ok);
        incr_len  = run >= CW'(16) ? CW'(16) : run >= CW'(8) ? CW'(8) : run >= CW'(4) ? CW'(4) : run;
        hburst    = is_single ? HB_SINGLE :
                    is_wrap ? (wb == CW'(4) ? HB_WRAP4 : wb == CW'(8) ? HB_WRAP8 : HB_WRAP16) :
                    run >= CW'(16) ? HB_INCR16 : run >= CW'(8) ? HB_INCR8 : run >= CW'(4) ? HB_INCR4 :
                    rem_x == CW'(1) ? HB_SINGLE : HB_INCR;
        chunk_len = RW'(is_single ? CW'(1) : is_wrap ? wb : incr_len);
    end
endmodule

// File: rtl/axi_ahb_burst_sequencer.sv
// axi_ahb_burst_sequencer: splits one AXI command into legal AHB bursts and drives the address phase
module axi_ahb_burst_sequencer
    import axi_ahb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [2:0]        cmd_size,
    input  logic [1:0]        cmd_burst,
    input  logic              hold,
    input  logic              hready,
    output logic [1:0]        htrans,
    output logic [ADDR_W-1:0] haddr,
    output logic [2:0]        hburst,
    output logic [2:0]        hsize,
    output logic              hwrite,
    output logic              beat_done,
    output logic              beat_last,
    output logic              cmd_err
);
    localparam int SIZE_MAX = $clog2(DATA_W / 8);
    localparam int CW = LEN_W + 1;
    seq_state_t        state, state_d;
    logic [ADDR_W-1:0] addr_d, next_addr, inc, wrap_mask, p_addr;
    logic [CW-1:0]     rem, rem_d, chunk, chunk_d, beats_q, p_rem, p_beats, plan_len;
    logic [2:0]        hburst_d, plan_burst, size_q, p_size;
    logic [1:0]        burst_q, p_burst;
    logic              write_q, accept, size_ok, idle, gap;
    assign cmd_ready = state == S_IDLE;
    assign accept    = cmd_valid && cmd_ready;
    assign size_ok   = cmd_size <= 3'(SIZE_MAX);
    assign beat_done = htrans[1] && hready;
    assign beat_last = beat_done && rem == CW'(1);
    assign hsize     = size_q;
    assign hwrite    = write_q;
    assign idle      = state == S_IDLE;
    assign gap       = state == S_GAP;
    assign inc       = ADDR_W'(1) << size_q;
    assign wrap_mask = (ADDR_W'(beats_q) << size_q) - ADDR_W'(1);
    assign next_addr = burst_q == AB_FIXED ? haddr :
                       burst_q == AB_WRAP ? (haddr & ~wrap_mask) | ((haddr + inc) & wrap_mask) : haddr + inc;
    // planner sees the command itself, a stalled chunk start, or the beat after the current one
    assign p_beats   = CW'(cmd_len) + CW'(1);
    assign p_addr    = idle ? cmd_addr : gap ? haddr : next_addr;
    assign p_rem     = idle ? p_beats : gap ? rem : rem - CW'(1);
    assign p_size    = idle ? cmd_size : size_q;
    assign p_burst   = idle ? cmd_burst : burst_q;
    axi_ahb_burst_planner #(.LEN_W(LEN_W)) u_planner (
        .addr_lo    (p_addr[9:0]),
        .remaining  (p_rem),
        .size       (p_size),
        .burst      (p_burst),
        .wrap_beats (idle ? p_beats : beats_q),
        .hburst     (plan_burst),
        .chunk_len  (plan_len)
    );
    always_comb begin
        state_d  = state;
        addr_d   = haddr;
        hburst_d = hburst;
        rem_d    = rem;
        chunk_d  = chunk;
        case (state)
            S_IDLE: if (accept && size_ok) begin
                state_d  = S_FIRST;
                addr_d   = cmd_addr;
                rem_d    = p_rem;
                chunk_d  = plan_len;
                hburst_d = plan_burst;
            end
            S_FIRST, S_NEXT: if (hready) begin
                if (rem == CW'(1)) state_d = S_IDLE;
                else begin
                    addr_d  = next_addr;
                    rem_d   = p_rem;
                    chunk_d = chunk - CW'(1);
                    state_d = hold ? S_BUSY : S_NEXT;
                    if (chunk == CW'(1)) begin
                        state_d  = hold ? S_GAP : S_FIRST;
                        chunk_d  = hold ? chunk : plan_len;
                        hburst_d = hold ? hburst : plan_burst;
                    end
                end
            end
            S_BUSY: if (hready && !hold) state_d = S_NEXT;
            S_GAP: if (hready && !hold) begin
                state_d  = S_FIRST;
                chunk_d  = plan_len;
                hburst_d = plan_burst;
            end
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            htrans  <= HT_IDLE;
            haddr   <= '0;
            hburst  <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
            burst_q <= '0;
            beats_q <= '0;
            rem     <= '0;
            chunk   <= '0;
            cmd_err <= 1'b0;
        end else begin
            state   <= state_d;
            htrans  <= trans_of(state_d);
            haddr   <= addr_d;
            hburst  <= hburst_d;
            rem     <= rem_d;
            chunk   <= chunk_d;
            cmd_err <= accept && !size_ok;
            if (accept && size_ok) begin
                size_q  <= cmd_size;
                write_q <= cmd_write;
                burst_q <= cmd_burst;
                beats_q <= p_beats;
            end
        end
    end
endmodule
